serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
Bit-serial adder controller that time-shares a single full_adder cell to add two WIDTH-bit operands, one bit per clock, LSB first.
- Owns operand shift registers, carry flip-flop, bit counter and a start/busy/done handshake.
- Sits between a requester (test sequencer or ALU front-end) and the 1-bit full_adder datapath.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 2..32).

Ports:
clk    input   1      rising-edge clock
rst    input   1      synchronous, active-high reset
start  input   1      request; sampled only in IDLE
a      input   WIDTH  operand A, captured on the accepted start edge
b      input   WIDTH  operand B, captured on the accepted start edge
cin    input   1      carry-in, captured on the accepted start edge
busy   output  1      high in RUN and DONE
done   output  1      one-cycle pulse; result valid
sum    output  WIDTH  result, held until the next accepted start
cout   output  1      final carry-out, held with sum

Behaviour:
- Clocking and reset:
  - Single clock; all state updates on the rising clk edge.
  - rst is synchronous and active-high, and has priority over everything.
  - Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry=0, shift regs=0.
- States: IDLE(00), RUN(01), DONE(10). Code 11 is illegal and recovers to IDLE on the next edge.
- IDLE:
  - start=1 at edge E0: load A_sh<=a, B_sh<=b, carry<=cin, cnt<=0, state<=RUN.
  - start=0: remain in IDLE. Outputs hold their last values.
- RUN:
  - Each edge feeds full_adder(A_sh[0], B_sh[0], carry).
  - sum_sh shifts right with the adder sum entering at the MSB. carry<=adder carry.
  - A_sh and B_sh shift right. cnt<=cnt+1.
  - At the edge where cnt==WIDTH-1: sum<=completed value, cout<=adder carry, state<=DONE.
- DONE:
  - done=1 for exactly this cycle.
  - Next edge: state<=IDLE.
- Latency:
  - done is high in the cycle after edge E_WIDTH, i.e. WIDTH edges after the start-sampling edge.
  - Throughput is one operation per WIDTH+2 cycles.
- Handshake:
  - start is ignored in RUN and DONE; no queuing.
  - A start held high continuously is re-accepted on the first IDLE edge.
- sum and cout update only at completion. They are stable from the done cycle until the next completion, or until reset.
- Result is modular: sum = (a+b+cin) mod 2^WIDTH; cout = bit WIDTH of the full sum.
- Reset mid-RUN aborts the operation. The partial result is never exposed; sum/cout return to 0.
- Counter width is clog2(WIDTH); there is no wrap inside RUN.

Optional Feature:
SERIAL_ADD_OVF_EN
- Defined:
  - Extra output port ovf (1 bit): signed two's-complement overflow, computed as carry-into-MSB XOR cout.
  - ovf is registered with sum/cout. Reset value 0.
- Undefined: the ovf port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared include serial_add_defs.vh holds:
  - state codes ST_IDLE=2'b00, ST_RUN=2'b01, ST_DONE=2'b10;
  - the default WIDTH constant.
- One sub-module: a single instance of the existing full_adder (ports a, b, cin, sum, carry) as the datapath cell.
- All control (FSM, counter, shift regs) stays in serial_add_ctrl.

Test Plan:
- WIDTH=8: a=0x0F, b=0x01, cin=0, 1-cycle start -> done exactly 8 edges after the start edge; sum=0x10, cout=0; busy high 9 cycles.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Start re-pulsed at RUN cycle 3 with a=0x55 -> ignored; result of the first op unchanged; no extra done.
- rst asserted at RUN cycle 4 -> next edge: state IDLE, busy=0, sum=0, cout=0, no done. A following op a=0x12, b=0x34 -> sum=0x46.
- start held high for 30 cycles with a=0x01, b=0x02 -> done pulses every 10 cycles (WIDTH+2); sum=0x03 each time.
- SERIAL_ADD_OVF_EN defined:
  - 0x7F+0x01 -> sum=0x80, ovf=1;
  - 0x80+0x80 -> sum=0x00, cout=1, ovf=1;
  - 0x10+0x20 -> ovf=0.

Source files
------------

// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state codes and
// the default operand width.
package serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam int SA_DEFAULT_WIDTH = 8;

endpackage : serial_add_ctrl_pkg

// File: rtl/serial_add_ctrl_fa.sv
// One-bit full adder cell, time-shared by the serial adder controller.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));

endmodule : full_adder

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands LSB first through a
// single full_adder. Optional macro SERIAL_ADD_OVF_EN adds a signed-overflow output.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e            state_q;
    logic [WIDTH-1:0]  a_sh_q;
    logic [WIDTH-1:0]  b_sh_q;
    logic [WIDTH-1:0]  sum_sh_q;
    logic [WIDTH-1:0]  sum_sh_d;
    logic              carry_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;
    logic              done_q;
    logic [WIDTH-1:0]  sum_q;
    logic              cout_q;
    logic              fa_sum_s;
    logic              fa_carry_s;
`ifdef SERIAL_ADD_OVF_EN
    logic              ovf_q;
`endif

    full_adder u_fa (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .cin   (carry_q),
        .sum   (fa_sum_s),
        .carry (fa_carry_s)
    );

    // Newest sum bit enters at the MSB so the final shift yields the full result.
    assign sum_sh_d = {fa_sum_s, sum_sh_q[WIDTH-1:1]};

    // Control FSM, operand/result shifting and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_sh_q   <= {1'b0, a_sh_q[WIDTH-1:1]};
                    b_sh_q   <= {1'b0, b_sh_q[WIDTH-1:1]};
                    sum_sh_q <= sum_sh_d;
                    carry_q  <= fa_carry_s;
                    cnt_q    <= cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        sum_q   <= sum_sh_d;
                        cout_q  <= fa_carry_s;
`ifdef SERIAL_ADD_OVF_EN
                        // carry_q here is the carry into the MSB position.
                        ovf_q   <= carry_q ^ fa_carry_s;
`endif
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl at WIDTH=8; ovf checks are
// compiled in when SERIAL_ADD_OVF_EN is defined.
module tb_serial_add_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
`ifdef SERIAL_ADD_OVF_EN
    logic       ovf;
`endif

    int errors;
    int checks;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle, wait (bounded) for done, check latency and result.
    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic cv, input logic [7:0] es, input logic ec);
        int n;
        start = 1'b1; a = av; b = bv; cin = cv;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd8);
        check({tag, "_sum"}, {24'd0, sum}, {24'd0, es});
        check({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
        @(negedge clk);
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;
        int done_at;
        int done_times[$];

        errors = 0;
        checks = 0;
        rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", {24'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 0x0F + 0x01: done 8 edges after start, busy for 9 cycles.
        start = 1'b1; a = 8'h0F; b = 8'h01; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        for (int i = 0; i < 12; i++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = i;
            end
            @(negedge clk);
        end
        check("t1_busy_cycles", 32'(busy_cnt), 32'd9);
        check("t1_done_count", 32'(done_cnt), 32'd1);
        check("t1_done_at", 32'(done_at), 32'd8);
        check("t1_sum", {24'd0, sum}, 32'h10);
        check("t1_cout", {31'd0, cout}, 32'd0);

        run_op("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_op("ff_ff_c1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        run_op("a5_5a", 8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0);

        // Start re-pulse during RUN must be ignored.
        start = 1'b1; a = 8'h20; b = 8'h03; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; a = 8'h55; b = 8'h55;
        @(negedge clk);
        start = 1'b0;
        done_cnt = 0; done_at = -1;
        for (int i = 3; i < 14; i++) begin
            if (done) begin
                done_cnt++;
                done_at = i;
                check("ign_sum", {24'd0, sum}, 32'h23);
            end
            @(negedge clk);
        end
        check("ign_done_count", 32'(done_cnt), 32'd1);
        check("ign_done_at", 32'(done_at), 32'd8);
        check("ign_busy_after", {31'd0, busy}, 32'd0);
        check("ign_sum_held", {24'd0, sum}, 32'h23);

        // Reset mid-RUN aborts and clears the held result.
        start = 1'b1; a = 8'hAA; b = 8'h0F; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_sum", {24'd0, sum}, 32'd0);
        check("abort_cout", {31'd0, cout}, 32'd0);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        run_op("post_abort", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

        // Start held high: one operation every WIDTH+2 cycles.
        start = 1'b1; a = 8'h01; b = 8'h02; cin = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                done_times.push_back(i);
                check("held_sum", {24'd0, sum}, 32'h03);
            end
        end
        start = 1'b0;
        check("held_done_count", 32'(done_times.size()), 32'd3);
        if (done_times.size() == 3) begin
            check("held_first", 32'(done_times[0]), 32'd8);
            check("held_period1", 32'(done_times[1] - done_times[0]), 32'd10);
            check("held_period2", 32'(done_times[2] - done_times[1]), 32'd10);
        end
        repeat (3) @(negedge clk);
        check("held_idle", {31'd0, busy}, 32'd0);

`ifdef SERIAL_ADD_OVF_EN
        run_op("ovf_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
        check("ovf_7f_01_ovf", {31'd0, ovf}, 32'd1);
        run_op("ovf_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
        check("ovf_80_80_ovf", {31'd0, ovf}, 32'd1);
        run_op("ovf_10_20", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);
        check("ovf_10_20_ovf", {31'd0, ovf}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_serial_add_ctrl
